// File: rtl/taxi_axil_reg_slice.sv
// ============================================================================
// taxi_axil_reg_slice : single-channel AXI4-Lite register slice
//   bypass / simple buffer / skid buffer, 1-8 cascaded stages, occupancy out
//   optional: TAXI_AXIL_REG_SLICE_STATS_EN adds the xfer_count port
// Revision: 1.0
// ============================================================================
`default_nettype none

module taxi_axil_reg_slice #(
  parameter int DATA_W   = 32,
  parameter int REG_TYPE = 2,
  parameter int STAGES   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [DATA_W-1:0]                m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
  ,
  output logic [31:0]                      xfer_count
`endif
);

  localparam int c_occ_w = $clog2(2*STAGES+1);

  generate
    if (REG_TYPE == 0) begin : g_bypass
      logic w_unused;
      assign w_unused  = ^{1'b0, clk, rst};
      assign m_data    = s_data;
      assign m_valid   = s_valid;
      assign s_ready   = m_ready;
      assign occupancy = '0;
    end else begin : g_slice
      // Index k is the s-side of stage k; index k+1 is its m-side.
      logic [STAGES:0][DATA_W-1:0] w_data;
      logic [STAGES:0]             w_valid;
      logic [STAGES:0]             w_ready;
      logic [STAGES-1:0]           w_occ0;
      logic [STAGES-1:0]           w_occ1;
      logic [c_occ_w-1:0]          w_occ_sum;

      assign w_data[0]       = s_data;
      assign w_valid[0]      = s_valid;
      assign s_ready         = w_ready[0];
      assign m_data          = w_data[STAGES];
      assign m_valid         = w_valid[STAGES];
      assign w_ready[STAGES] = m_ready;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (REG_TYPE == 1) begin : g_simple
          logic [DATA_W-1:0] data_q, data_d;
          logic              full_q, full_d;
          logic              rdy_q;

          always_comb begin
            full_d = full_q;
            data_d = data_q;
            if (rdy_q && w_valid[k]) begin
              full_d = 1'b1;
              data_d = w_data[k];
            end else if (full_q && w_ready[k+1]) begin
              full_d = 1'b0;
            end
          end

          always_ff @(posedge clk) begin
            if (rst) begin
              full_q <= 1'b0;
              rdy_q  <= 1'b0;
            end else begin
              full_q <= full_d;
              rdy_q  <= !full_d;
            end
          end

          always_ff @(posedge clk) begin
            data_q <= data_d;
          end

          assign w_ready[k]   = rdy_q;
          assign w_valid[k+1] = full_q;
          assign w_data[k+1]  = data_q;
          assign w_occ0[k]    = full_q;
          assign w_occ1[k]    = 1'b0;
        end else begin : g_skid
          logic [DATA_W-1:0] out_data_q, out_data_d;
          logic [DATA_W-1:0] skid_data_q, skid_data_d;
          logic              out_valid_q, out_valid_d;
          logic              skid_valid_q, skid_valid_d;
          logic              rdy_q;
          logic              w_acc;
          logic              w_drain;

          assign w_acc   = rdy_q && w_valid[k];
          assign w_drain = out_valid_q && w_ready[k+1];

          always_comb begin
            out_data_d   = out_data_q;
            out_valid_d  = out_valid_q;
            skid_data_d  = skid_data_q;
            skid_valid_d = skid_valid_q;
            if (!out_valid_q || w_drain) begin
              // Skid holds the older entry, so it always goes first.
              if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
              end else begin
                out_valid_d = w_acc;
                if (w_acc) begin
                  out_data_d = w_data[k];
                end
              end
            end else if (w_acc) begin
              skid_valid_d = 1'b1;
              skid_data_d  = w_data[k];
            end
          end

          always_ff @(posedge clk) begin
            if (rst) begin
              out_valid_q  <= 1'b0;
              skid_valid_q <= 1'b0;
              rdy_q        <= 1'b0;
            end else begin
              out_valid_q  <= out_valid_d;
              skid_valid_q <= skid_valid_d;
              rdy_q        <= !skid_valid_d;
            end
          end

          always_ff @(posedge clk) begin
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
          end

          assign w_ready[k]   = rdy_q;
          assign w_valid[k+1] = out_valid_q;
          assign w_data[k+1]  = out_data_q;
          assign w_occ0[k]    = out_valid_q;
          assign w_occ1[k]    = skid_valid_q;
        end
      end

      always_comb begin
        w_occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
          w_occ_sum = w_occ_sum + c_occ_w'(w_occ0[i]) + c_occ_w'(w_occ1[i]);
        end
      end

      assign occupancy = w_occ_sum;
    end
  endgenerate

`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
  logic [31:0] xfer_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else if (m_valid && m_ready) begin
      xfer_count_q <= xfer_count_q + 32'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_taxi_axil_reg_slice.sv
// ============================================================================
// tb_taxi_axil_reg_slice : scoreboard bench over six slice configurations
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_taxi_axil_reg_slice;

  // 0: skid S3, 1: skid S2, 2: simple S1, 3: bypass, 4: skid S4, 5: skid S1
  logic       clk;
  logic       rst;
  logic [7:0] sd [6];
  logic       sv [6];
  logic       sr [6];
  logic [7:0] md [6];
  logic       mv [6];
  logic       mr [6];
  logic [2:0] occ_a;
  logic [2:0] occ_b;
  logic [1:0] occ_c;
  logic [1:0] occ_d;
  logic [3:0] occ_e;
  logic [1:0] occ_f;
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
  logic [31:0] xc [6];
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] sbq [6][$];
  logic [7:0] sb_exp;

  taxi_axil_reg_slice #(.DATA_W(8), .REG_TYPE(2), .STAGES(3)) u_a (
    .clk(clk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(sr[0]),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]), .occupancy(occ_a)
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    , .xfer_count(xc[0])
`endif
  );

  taxi_axil_reg_slice #(.DATA_W(8), .REG_TYPE(2), .STAGES(2)) u_b (
    .clk(clk), .rst(rst), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(sr[1]),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]), .occupancy(occ_b)
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    , .xfer_count(xc[1])
`endif
  );

  taxi_axil_reg_slice #(.DATA_W(8), .REG_TYPE(1), .STAGES(1)) u_c (
    .clk(clk), .rst(rst), .s_data(sd[2]), .s_valid(sv[2]), .s_ready(sr[2]),
    .m_data(md[2]), .m_valid(mv[2]), .m_ready(mr[2]), .occupancy(occ_c)
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    , .xfer_count(xc[2])
`endif
  );

  taxi_axil_reg_slice #(.DATA_W(8), .REG_TYPE(0), .STAGES(1)) u_d (
    .clk(clk), .rst(rst), .s_data(sd[3]), .s_valid(sv[3]), .s_ready(sr[3]),
    .m_data(md[3]), .m_valid(mv[3]), .m_ready(mr[3]), .occupancy(occ_d)
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    , .xfer_count(xc[3])
`endif
  );

  taxi_axil_reg_slice #(.DATA_W(8), .REG_TYPE(2), .STAGES(4)) u_e (
    .clk(clk), .rst(rst), .s_data(sd[4]), .s_valid(sv[4]), .s_ready(sr[4]),
    .m_data(md[4]), .m_valid(mv[4]), .m_ready(mr[4]), .occupancy(occ_e)
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    , .xfer_count(xc[4])
`endif
  );

  taxi_axil_reg_slice #(.DATA_W(8), .REG_TYPE(2), .STAGES(1)) u_f (
    .clk(clk), .rst(rst), .s_data(sd[5]), .s_valid(sv[5]), .s_ready(sr[5]),
    .m_data(md[5]), .m_valid(mv[5]), .m_ready(mr[5]), .occupancy(occ_f)
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    , .xfer_count(xc[5])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted payloads queue up, emitted payloads must match in order.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        sbq[i].delete();
      end else begin
        if (sv[i] && sr[i]) sbq[i].push_back(sd[i]);
        if (mv[i] && mr[i]) begin
          if (sbq[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected[%0d]: got 0x%02h, expected no output", i, md[i]);
          end else begin
            sb_exp = sbq[i].pop_front();
            check($sformatf("sb_data[%0d]", i), int'(md[i]), int'(sb_exp));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ok, acc, outs, bad;
    logic a;

    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sd[i] = 8'h00;
      sv[i] = 1'b0;
      mr[i] = 1'b0;
    end

    // ---- reset state and latency (skid, 3 stages)
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_s_ready_a", int'(sr[0]), 0);
    check("rst_s_ready_c", int'(sr[2]), 0);
    check("rst_m_valid_a", int'(mv[0]), 0);
    check("rst_occ_a", int'(occ_a), 0);
    cyc();
    rst = 1'b0;
    cyc();
    sv[0] = 1'b1;
    sd[0] = 8'hA5;
    @(negedge clk);
    check("post_rst_s_ready_a", int'(sr[0]), 1);
    check("lat_a_c0", int'(mv[0]), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 1) sv[0] = 1'b0;
      @(negedge clk);
      check($sformatf("lat_a_c%0d", k), int'(mv[0]), (k == 3) ? 1 : 0);
      if (k == 3) check("lat_a_data", int'(md[0]), 8'hA5);
    end
    cyc();
    mr[0] = 1'b1;
    cyc();

    // ---- fill skid S2 with m_ready low, then drain in order
    sv[1] = 1'b1;
    sd[1] = 8'd1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = sv[1] && sr[1];
      if (a) n++;
      cyc();
      if (a) sd[1] = sd[1] + 8'd1;
    end
    sv[1] = 1'b0;
    @(negedge clk);
    check("full_b_accepted", n, 4);
    check("full_b_s_ready", int'(sr[1]), 0);
    check("full_b_occ", int'(occ_b), 4);
    cyc();
    mr[1] = 1'b1;
    ok = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mv[1]) ok++;
      cyc();
    end
    check("drain_b_back_to_back", ok, 4);
    @(negedge clk);
    check("drain_b_empty_occ", int'(occ_b), 0);
    cyc();

    // ---- simple S1: one transfer every two cycles
    mr[2] = 1'b1;
    sv[2] = 1'b1;
    sd[2] = 8'h10;
    n = 0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a = sv[2] && sr[2];
      if (a) n++;
      if (sr[2] == ((c % 2) == 0)) ok++;
      cyc();
      if (a) sd[2] = sd[2] + 8'd1;
    end
    sv[2] = 1'b0;
    check("simple_c_accepted", n, 10);
    check("simple_c_alternating", ok, 20);
    cyc();

    // ---- bypass with random stalls
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      sv[3] = 1'($urandom_range(0, 1));
      mr[3] = 1'($urandom_range(0, 1));
      sd[3] = 8'($urandom);
      @(negedge clk);
      if (md[3] == sd[3] && mv[3] == sv[3] && sr[3] == mr[3] && occ_d == 2'd0) ok++;
    end
    check("bypass_follow", ok, 40);
    cyc();
    sv[3] = 1'b0;
    cyc();

    // ---- skid S1 full throughput for 100 cycles
    sv[5] = 1'b1;
    mr[5] = 1'b1;
    sd[5] = 8'd0;
    acc = 0;
    outs = 0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      a = sv[5] && sr[5];
      if (a) acc++;
      if (mv[5] && mr[5]) outs++;
      if (occ_f > 2'd1) bad++;
      cyc();
      if (a) sd[5] = sd[5] + 8'd1;
    end
    sv[5] = 1'b0;
    check("tput_f_accepted", acc, 100);
    check("tput_f_out_window", outs, 99);
    check("tput_f_occ_le1", bad, 0);
    @(negedge clk);
    if (mv[5] && mr[5]) outs++;
    check("tput_f_out_total", outs, 100);
    cyc();
    @(negedge clk);
`ifdef TAXI_AXIL_REG_SLICE_STATS_EN
    check("tput_f_xfer_count", int'(xc[5]), 100);
`endif
    check("tput_f_drained", int'(occ_f), 0);
    cyc();

    // ---- skid S4: hold 6 entries, reset, then fresh data
    sv[4] = 1'b1;
    sd[4] = 8'h50;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      @(negedge clk);
      a = sv[4] && sr[4];
      if (a) n++;
      cyc();
      if (a) sd[4] = sd[4] + 8'd1;
      if (n == 6) sv[4] = 1'b0;
    end
    sv[4] = 1'b0;
    check("hold_e_accepted", n, 6);
    @(negedge clk);
    check("hold_e_occ", int'(occ_e), 6);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_e_occ", int'(occ_e), 0);
    check("mid_rst_e_m_valid", int'(mv[4]), 0);
    cyc();
    mr[4] = 1'b1;
    sv[4] = 1'b1;
    sd[4] = 8'h3C;
    @(negedge clk);
    check("fresh_e_s_ready", int'(sr[4]), 1);
    check("fresh_e_c0", int'(mv[4]), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) sv[4] = 1'b0;
      @(negedge clk);
      check($sformatf("fresh_e_c%0d", k), int'(mv[4]), (k == 4) ? 1 : 0);
      if (k == 4) check("fresh_e_data", int'(md[4]), 8'h3C);
    end
    repeat (10) cyc();
    @(negedge clk);
    check("final_e_occ", int'(occ_e), 0);
    check("final_e_queue", sbq[4].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
